// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 raster constants, raster position type and window helper
package vga_timing_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_H_TOTAL     = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL     = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int DEF_HSYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int DEF_HSYNC_END   = DEF_HSYNC_START + DEF_H_SYNC;
    localparam int DEF_VSYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int DEF_VSYNC_END   = DEF_VSYNC_START + DEF_V_SYNC;

    typedef struct packed {
        int   row;
        int   column;
        logic display_enable;
    } raster_pos_t;

    function automatic logic in_window(input int value, input int start, input int length);
        return (value >= start) && (value < start + length);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - reset-to-1 shift register that delays active-low sync signals
module sync_delay_line #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 1
) (
    input  logic             vga_clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Idle level of an active-low sync is 1, so every stage resets inactive.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '1;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_generator.sv
// rtl/vga_timing_generator.sv - free-running VGA raster counters, syncs and frame pulses; VGA_SYNC_DELAY_EN adds sync lag
module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = DEF_H_VISIBLE,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_VISIBLE  = DEF_V_VISIBLE,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK,
    parameter int SYNC_DELAY = 1
) (
    input  logic       vga_clock,
    input  logic       reset,
    output int         column,
    output int         row,
    output logic       display_enable,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL     = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL     = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HSYNC_START = H_VISIBLE + H_FRONT;
    localparam int VSYNC_START = V_VISIBLE + V_FRONT;

    raster_pos_t next_pos;
    logic        hsync_q;
    logic        vsync_q;
    logic        next_is_origin;

    always_comb begin
        next_pos.column = column + 1;
        next_pos.row    = row;
        if (column >= H_TOTAL - 1) begin
            next_pos.column = 0;
            next_pos.row    = (row >= V_TOTAL - 1) ? 0 : row + 1;
        end
        next_pos.display_enable = (next_pos.column < H_VISIBLE) && (next_pos.row < V_VISIBLE);
        next_is_origin          = (next_pos.column == 0) && (next_pos.row == 0);
    end

    // Reset parks the counters on the last pixel so the first edge lands on (0,0).
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            column         <= H_TOTAL - 1;
            row            <= V_TOTAL - 1;
            display_enable <= 1'b0;
            line_start     <= 1'b0;
            frame_start    <= 1'b0;
            frame_count    <= 8'd0;
            hsync_q        <= 1'b1;
            vsync_q        <= 1'b1;
        end else begin
            column         <= next_pos.column;
            row            <= next_pos.row;
            display_enable <= next_pos.display_enable;
            line_start     <= (next_pos.column == 0);
            frame_start    <= next_is_origin;
            hsync_q        <= !in_window(next_pos.column, HSYNC_START, H_SYNC);
            vsync_q        <= !in_window(next_pos.row, VSYNC_START, V_SYNC);
            if (next_is_origin) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    logic [1:0] sync_delayed;

    sync_delay_line #(
        .WIDTH (2),
        .DEPTH (SYNC_DELAY)
    ) u_sync_delay (
        .vga_clock (vga_clock),
        .reset     (reset),
        .din       ({hsync_q, vsync_q}),
        .dout      (sync_delayed)
    );

    assign hsync = sync_delayed[1];
    assign vsync = sync_delayed[0];
`else
    // Without the delay line the syncs stay aligned with the counters.
    if (SYNC_DELAY >= 0) begin : g_sync_direct
        assign hsync = hsync_q;
        assign vsync = vsync_q;
    end
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// tb/tb_vga_timing_generator.sv - bench for vga_timing_generator against a cycle-index raster model
module tb_vga_timing_generator;

    localparam int SD = 2;
`ifdef VGA_SYNC_DELAY_EN
    localparam int LAG = SD;
`else
    localparam int LAG = 0;
`endif

    localparam int F_HV = 640, F_HF = 16, F_HW = 96, F_HB = 48;
    localparam int F_VV = 480, F_VF = 10, F_VW = 2,  F_VB = 33;
    localparam int S_HV = 12,  S_HF = 2,  S_HW = 3,  S_HB = 3;
    localparam int S_VV = 6,   S_VF = 2,  S_VW = 2,  S_VB = 2;
    localparam int S_FRAME = (S_HV + S_HF + S_HW + S_HB) * (S_VV + S_VF + S_VW + S_VB);

    typedef struct packed {
        int         col;
        int         row;
        logic       de;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    int f_col, f_row, s_col, s_row;
    logic f_de, f_hs, f_vs, f_ls, f_fs, s_de, s_hs, s_vs, s_ls, s_fs;
    logic [7:0] f_fc, s_fc;

    int tests = 0;
    int fails = 0;
    int t = 0;
    bit mon_f = 0;
    bit mon_s = 0;
    exp_t ef, es;

    always #5 clk = ~clk;

    vga_timing_generator #(.SYNC_DELAY(SD)) dut_full (
        .vga_clock(clk), .reset(rst_n), .column(f_col), .row(f_row),
        .display_enable(f_de), .hsync(f_hs), .vsync(f_vs),
        .line_start(f_ls), .frame_start(f_fs), .frame_count(f_fc)
    );

    vga_timing_generator #(
        .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HW), .H_BACK(S_HB),
        .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VW), .V_BACK(S_VB),
        .SYNC_DELAY(SD)
    ) dut_small (
        .vga_clock(clk), .reset(rst_n), .column(s_col), .row(s_row),
        .display_enable(s_de), .hsync(s_hs), .vsync(s_vs),
        .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
    );

    // Expected outputs after tt clock edges out of reset (tt = 0 means in reset).
    function automatic exp_t model(input int tt, input int hv, input int hf, input int hw, input int hb,
                                   input int vv, input int vf, input int vw, input int vb);
        exp_t e;
        int ht, vt, p, u;
        ht = hv + hf + hw + hb;
        vt = vv + vf + vw + vb;
        if (tt == 0) begin
            e.col = ht - 1; e.row = vt - 1; e.de = 0; e.ls = 0; e.fs = 0; e.fc = 8'd0;
        end else begin
            p = (tt - 1) % (ht * vt);
            e.col = p % ht;
            e.row = p / ht;
            e.de  = (e.col < hv) && (e.row < vv);
            e.ls  = (e.col == 0);
            e.fs  = (p == 0);
            e.fc  = 8'(((tt - 1) / (ht * vt) + 1) % 256);
        end
        u = tt - LAG;
        if (u <= 0) begin
            e.hs = 1; e.vs = 1;
        end else begin
            p = (u - 1) % (ht * vt);
            e.hs = !((p % ht) >= hv + hf && (p % ht) < hv + hf + hw);
            e.vs = !((p / ht) >= vv + vf && (p / ht) < vv + vf + vw);
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) t <= 0;
        else        t <= t + 1;
    end

    always @(negedge clk) begin
        if (mon_f) begin
            ef = model(t, F_HV, F_HF, F_HW, F_HB, F_VV, F_VF, F_VW, F_VB);
            tests++;
            if ({f_col, f_row, f_de, f_hs, f_vs, f_ls, f_fs, f_fc} !==
                {ef.col, ef.row, ef.de, ef.hs, ef.vs, ef.ls, ef.fs, ef.fc}) begin
                $display("FAIL model_full t=%0d got col=%0d row=%0d de=%b hs=%b vs=%b ls=%b fs=%b fc=%0d expected col=%0d row=%0d de=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
                         t, f_col, f_row, f_de, f_hs, f_vs, f_ls, f_fs, f_fc,
                         ef.col, ef.row, ef.de, ef.hs, ef.vs, ef.ls, ef.fs, ef.fc);
                fails++;
                mon_f = 0;
            end
        end
        if (mon_s) begin
            es = model(t, S_HV, S_HF, S_HW, S_HB, S_VV, S_VF, S_VW, S_VB);
            tests++;
            if ({s_col, s_row, s_de, s_hs, s_vs, s_ls, s_fs, s_fc} !==
                {es.col, es.row, es.de, es.hs, es.vs, es.ls, es.fs, es.fc}) begin
                $display("FAIL model_small t=%0d got col=%0d row=%0d de=%b hs=%b vs=%b ls=%b fs=%b fc=%0d expected col=%0d row=%0d de=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
                         t, s_col, s_row, s_de, s_hs, s_vs, s_ls, s_fs, s_fc,
                         es.col, es.row, es.de, es.hs, es.vs, es.ls, es.fs, es.fc);
                fails++;
                mon_s = 0;
            end
        end
    end

    task automatic test_reset();
        #2 rst_n = 0;
        @(negedge clk);
        mon_f = 1;
        mon_s = 1;
        repeat (4) @(negedge clk);
        tests++;
        if (f_col !== 799 || f_row !== 524 || f_de !== 1'b0 || f_hs !== 1'b1 || f_vs !== 1'b1 ||
            f_ls !== 1'b0 || f_fs !== 1'b0 || f_fc !== 8'd0)
            begin $display("FAIL reset_full: got col=%0d row=%0d de=%b hs=%b vs=%b fc=%0d, expected 799 524 0 1 1 0",
                           f_col, f_row, f_de, f_hs, f_vs, f_fc); fails++; end
        tests++;
        if (s_col !== 19 || s_row !== 11 || s_de !== 1'b0 || s_fs !== 1'b0 || s_fc !== 8'd0)
            begin $display("FAIL reset_small: got col=%0d row=%0d de=%b fs=%b fc=%0d, expected 19 11 0 0 0",
                           s_col, s_row, s_de, s_fs, s_fc); fails++; end
        rst_n = 1;
        @(negedge clk);
        tests++;
        if (f_col !== 0 || f_row !== 0 || f_de !== 1'b1 || f_ls !== 1'b1 || f_fs !== 1'b1 || f_fc !== 8'd1)
            begin $display("FAIL first_edge_full: got col=%0d row=%0d de=%b ls=%b fs=%b fc=%0d, expected 0 0 1 1 1 1",
                           f_col, f_row, f_de, f_ls, f_fs, f_fc); fails++; end
        tests++;
        if (s_col !== 0 || s_row !== 0 || s_fs !== 1'b1 || s_fc !== 8'd1)
            begin $display("FAIL first_edge_small: got col=%0d row=%0d fs=%b fc=%0d, expected 0 0 1 1",
                           s_col, s_row, s_fs, s_fc); fails++; end
    endtask

    task automatic test_line();
        int de_cnt = 0, hs_low = 0, ls_cnt = 0, fall_col = -1;
        logic prev_hs = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if (f_de === 1'b1) de_cnt++;
            if (f_hs === 1'b0) hs_low++;
            if (f_ls === 1'b1) ls_cnt++;
            if (prev_hs === 1'b1 && f_hs === 1'b0 && fall_col < 0) fall_col = f_col;
            prev_hs = f_hs;
            @(negedge clk);
        end
        tests++;
        if (de_cnt !== 640) begin $display("FAIL line_enable: got %0d, expected 640", de_cnt); fails++; end
        tests++;
        if (hs_low !== 96) begin $display("FAIL line_hsync_width: got %0d, expected 96", hs_low); fails++; end
        tests++;
        if (ls_cnt !== 1) begin $display("FAIL line_start_count: got %0d, expected 1", ls_cnt); fails++; end
        tests++;
        if (fall_col !== 656 + LAG)
            begin $display("FAIL hsync_fall_column: got %0d, expected %0d", fall_col, 656 + LAG); fails++; end
    endtask

    task automatic test_frames();
        int t0 = -1, t1 = -1, vs_low = 0;
        logic [7:0] fc0 = 8'd0, fc1 = 8'd0;
        for (int i = 0; i < 3 * S_FRAME && t1 < 0; i++) begin
            @(negedge clk);
            if (t0 >= 0 && s_fs === 1'b1) begin t1 = t; fc1 = s_fc; end
            else if (t0 < 0 && s_fs === 1'b1) begin t0 = t; fc0 = s_fc; end
            if (t0 >= 0 && t1 < 0 && s_vs === 1'b0) vs_low++;
        end
        tests++;
        if (t0 < 0 || t1 - t0 !== S_FRAME)
            begin $display("FAIL frame_spacing: got %0d, expected %0d", t1 - t0, S_FRAME); fails++; end
        tests++;
        if (vs_low !== S_VW * 20) begin $display("FAIL vsync_width: got %0d, expected %0d", vs_low, S_VW * 20); fails++; end
        tests++;
        if (fc1 !== 8'(fc0 + 8'd1)) begin $display("FAIL frame_count_step: got %0d, expected %0d", fc1, fc0 + 8'd1); fails++; end
    endtask

    task automatic test_frame_wrap();
        bit seen = 0;
        logic [7:0] prev = 8'd0;
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            if (s_fs === 1'b1) begin
                if (s_fc === 8'd0) begin seen = 1; break; end
                prev = s_fc;
            end
        end
        tests++;
        if (!seen) begin $display("FAIL wrap_timeout: got no frame_count 0, expected wrap"); fails++; end
        tests++;
        if (prev !== 8'd255) begin $display("FAIL wrap_previous: got %0d, expected 255", prev); fails++; end
        tests++;
        if (t !== 255 * S_FRAME + 1) begin $display("FAIL wrap_time: got %0d, expected %0d", t, 255 * S_FRAME + 1); fails++; end
    endtask

    task automatic test_mid_reset();
        int run_len, hold;
        run_len = $urandom_range(100, 3000);
        hold    = $urandom_range(1, 5);
        repeat (run_len) @(negedge clk);
        #2 rst_n = 0;
        #1;
        tests++;
        if (f_col !== 799 || f_row !== 524 || f_de !== 1'b0 || f_hs !== 1'b1 || f_vs !== 1'b1 ||
            f_ls !== 1'b0 || f_fs !== 1'b0 || f_fc !== 8'd0)
            begin $display("FAIL async_reset_full: got col=%0d row=%0d de=%b hs=%b vs=%b fc=%0d, expected 799 524 0 1 1 0",
                           f_col, f_row, f_de, f_hs, f_vs, f_fc); fails++; end
        tests++;
        if (s_col !== 19 || s_row !== 11 || s_hs !== 1'b1 || s_fc !== 8'd0)
            begin $display("FAIL async_reset_small: got col=%0d row=%0d hs=%b fc=%0d, expected 19 11 1 0",
                           s_col, s_row, s_hs, s_fc); fails++; end
        mon_f = 1;
        mon_s = 1;
        repeat (hold) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        tests++;
        if (f_col !== 0 || f_row !== 0 || f_fs !== 1'b1 || f_fc !== 8'd1)
            begin $display("FAIL restart_full: got col=%0d row=%0d fs=%b fc=%0d, expected 0 0 1 1",
                           f_col, f_row, f_fs, f_fc); fails++; end
        for (int i = 0; i < 1000 && t != 2 * S_FRAME + 1; i++) @(negedge clk);
        tests++;
        if (t !== 2 * S_FRAME + 1 || s_fs !== 1'b1 || s_fc !== 8'd3)
            begin $display("FAIL third_frame_count: got t=%0d fs=%b fc=%0d, expected t=%0d fs=1 fc=3",
                           t, s_fs, s_fc, 2 * S_FRAME + 1); fails++; end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frames();
        test_frame_wrap();
        repeat (2) test_mid_reset();
        @(negedge clk);
        mon_f = 0;
        mon_s = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
